// File: rtl/nocpe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nocpe_pkg
//  Description : Shared constants and the saturating/wrapping accumulate
//                helper used by every PE of the nocpe_row chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package nocpe_pkg;

    localparam int c_dw_default = 16;
    localparam int c_aw_default = 32;
    // Widest accumulator the helper can handle; AW of any instance must not exceed it.
    localparam int c_max_aw     = 64;

    typedef struct packed {
        logic                ovf;
        logic [c_max_aw-1:0] sum;
    } sat_res_t;

    // Adds two values that are each below 2^aw at (aw+1)-bit precision.
    // On carry-out the result clamps to 2^aw-1 (sat=1) or wraps (sat=0),
    // and ovf reports the carry in both cases.
    function automatic sat_res_t sat_add(
        input logic [c_max_aw-1:0] acc,
        input logic [c_max_aw-1:0] addend,
        input int                  aw,
        input logic                sat
    );
        logic [c_max_aw:0] sum;
        logic [c_max_aw:0] mask;
        sat_res_t          r;
        sum   = {1'b0, acc} + {1'b0, addend};
        mask  = ~({(c_max_aw + 1){1'b1}} << aw);
        r.ovf = |(sum & ~mask);
        if (r.ovf && sat) begin
            sum = mask;
        end else begin
            sum = sum & mask;
        end
        r.sum = sum[c_max_aw-1:0];
        return r;
    endfunction

endpackage : nocpe_pkg
`default_nettype wire

// File: rtl/nocpe_row_if.sv
`default_nettype none
// ============================================================================
//  Module      : nocpe_row_if
//  Description : Beat input (in_valid/clr/b), local operands and the per-PE
//                accumulator / strobe / overflow outputs of a nocpe_row.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nocpe_row_if
    import nocpe_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = c_dw_default,
    parameter int AW = c_aw_default
) ();

    logic            in_valid;
    logic            clr;
    logic [DW-1:0]   b;
    logic [N*DW-1:0] a;
    logic [N*AW-1:0] c;
    logic [N-1:0]    c_valid;
    logic [N-1:0]    ovf;

    modport master (
        output in_valid, clr, b, a,
        input  c, c_valid, ovf
    );

    modport slave (
        input  in_valid, clr, b, a,
        output c, c_valid, ovf
    );

endinterface : nocpe_row_if
`default_nettype wire

// File: rtl/nocpe_cell.sv
`default_nettype none
// ============================================================================
//  Module      : nocpe_cell
//  Description : One processing element: multiply-accumulate of the passing
//                operand b with the local operand a, sticky overflow, output
//                strobe, and the registers that forward b/valid/clr to the
//                next PE one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module nocpe_cell
    import nocpe_pkg::*;
#(
    parameter int DW  = c_dw_default,
    parameter int AW  = c_aw_default,
    parameter bit SAT = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          v_i,
    input  wire logic          clr_i,
    input  wire logic [DW-1:0] b_i,
    input  wire logic [DW-1:0] a_i,
    output logic               v_o,
    output logic               clr_o,
    output logic [DW-1:0]      b_o,
    output logic [AW-1:0]      c_o,
    output logic               c_valid_o,
    output logic               ovf_o
);

    logic                v_q;
    logic                clr_q;
    logic [DW-1:0]       b_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       acc_d;
    logic                ovf_q;
    logic                ovf_d;
    logic                cv_q;
    logic [2*DW-1:0]     w_prod;
    logic [c_max_aw-1:0] w_base;
    sat_res_t            w_res;

    // Next accumulator/overflow: a clr beat restarts from zero and drops the old flag.
    always_comb begin
        w_prod = (2*DW)'(a_i) * (2*DW)'(b_i);
        w_base = '0;
        if (!clr_i) begin
            w_base[AW-1:0] = acc_q;
        end
        w_res = sat_add(w_base, c_max_aw'(w_prod), AW, SAT);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (v_i) begin
            acc_d = w_res.sum[AW-1:0];
            ovf_d = (ovf_q & ~clr_i) | w_res.ovf;
        end
    end

    // Upper helper bits above AW are always zero after masking.
    if (AW < c_max_aw) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_res.sum[c_max_aw-1:AW];
    end

    // State and forwarding registers; reset discards any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= 1'b0;
            clr_q <= 1'b0;
            b_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            cv_q  <= 1'b0;
        end else begin
            v_q   <= v_i;
            clr_q <= v_i & clr_i;
            b_q   <= b_i;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cv_q  <= v_i;
        end
    end

    assign v_o       = v_q;
    assign clr_o     = clr_q;
    assign b_o       = b_q;
    assign c_o       = acc_q;
    assign c_valid_o = cv_q;
    assign ovf_o     = ovf_q;

endmodule : nocpe_cell
`default_nettype wire

// File: rtl/nocpe_row.sv
`default_nettype none
// ============================================================================
//  Module      : nocpe_row
//  Description : 1xN chain of nocpe_cell PEs. The shared operand b with its
//                valid/clr tags enters PE 0 and moves one PE per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module nocpe_row
    import nocpe_pkg::*;
#(
    parameter int N   = 4,
    parameter int DW  = c_dw_default,
    parameter int AW  = c_aw_default,
    parameter bit SAT = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    nocpe_row_if.slave bus
);

    logic            w_v   [0:N];
    logic            w_clr [0:N];
    logic [DW-1:0]   w_b   [0:N];
    logic [N*AW-1:0] w_c;
    logic [N-1:0]    w_cv;
    logic [N-1:0]    w_ovf;

    assign w_v[0]      = bus.in_valid;
    assign w_clr[0]    = bus.clr;
    assign w_b[0]      = bus.b;
    assign bus.c       = w_c;
    assign bus.c_valid = w_cv;
    assign bus.ovf     = w_ovf;

    for (genvar i = 0; i < N; i++) begin : g_pe
        nocpe_cell #(
            .DW  (DW),
            .AW  (AW),
            .SAT (SAT)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .v_i       (w_v[i]),
            .clr_i     (w_clr[i]),
            .b_i       (w_b[i]),
            .a_i       (bus.a[i*DW +: DW]),
            .v_o       (w_v[i+1]),
            .clr_o     (w_clr[i+1]),
            .b_o       (w_b[i+1]),
            .c_o       (w_c[i*AW +: AW]),
            .c_valid_o (w_cv[i]),
            .ovf_o     (w_ovf[i])
        );
    end

    // The last PE's forwarded copies have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = w_v[N] ^ w_clr[N] ^ (^w_b[N]);

endmodule : nocpe_row
`default_nettype wire

// File: tb/tb_nocpe_row.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nocpe_row
//  Description : Scoreboard bench for nocpe_row. A saturating and a wrapping
//                instance share the same stimulus; expected per-PE results
//                and their arrival edge are queued when a beat is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nocpe_row;

    localparam int NPE  = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int CMAX = (1 << AW) - 1;

    typedef struct {
        int c;
        bit ovf;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nocpe_row_if #(.N(NPE), .DW(DW), .AW(AW)) bus0 ();
    nocpe_row_if #(.N(NPE), .DW(DW), .AW(AW)) bus1 ();

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.clr      = bus0.clr;
    assign bus1.b        = bus0.b;
    assign bus1.a        = bus0.a;

    nocpe_row #(.N(NPE), .DW(DW), .AW(AW), .SAT(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    nocpe_row #(.N(NPE), .DW(DW), .AW(AW), .SAT(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    exp_t sb     [2][NPE][$];
    int   macc   [2][NPE];
    bit   movf   [2][NPE];
    int   last_c [2][NPE];
    bit   last_o [2][NPE];
    int   nvec = 0;
    int   nmis = 0;
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int get_c(input int s, input int i);
        return (s == 0) ? int'(bus0.c[i*AW +: AW]) : int'(bus1.c[i*AW +: AW]);
    endfunction

    function automatic bit get_cv(input int s, input int i);
        return (s == 0) ? bus0.c_valid[i] : bus1.c_valid[i];
    endfunction

    function automatic bit get_ovf(input int s, input int i);
        return (s == 0) ? bus0.ovf[i] : bus1.ovf[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_a(input int i, input int val);
        bus0.a[i*DW +: DW] = val[DW-1:0];
    endtask

    // Issue one beat; queue the result every PE must show at edge (now+1+i).
    task automatic beat(input bit clr, input int b);
        int ai, base, sum, v;
        bit o, ov;
        bus0.in_valid = 1'b1;
        bus0.clr      = clr;
        bus0.b        = b[DW-1:0];
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NPE; i++) begin
                ai   = int'(bus0.a[i*DW +: DW]);
                base = clr ? 0 : macc[s][i];
                o    = clr ? 1'b0 : movf[s][i];
                sum  = base + ai * b;
                ov   = (sum > CMAX);
                v    = ov ? ((s == 0) ? CMAX : (sum & CMAX)) : sum;
                macc[s][i] = v;
                movf[s][i] = o | ov;
                sb[s][i].push_back('{c: v, ovf: o | ov, cyc: cyc + 1 + i});
            end
        end
        tick();
        bus0.in_valid = 1'b0;
        bus0.clr      = 1'b0;
    endtask

    // Idle cycles; clr is held high to show it is ignored without in_valid.
    task automatic idle(input int n);
        bus0.in_valid = 1'b0;
        bus0.clr      = 1'b1;
        bus0.b        = '1;
        repeat (n) tick();
        bus0.clr      = 1'b0;
    endtask

    task automatic flush();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NPE; i++) begin
                sb[s][i].delete();
                macc[s][i]   = 0;
                movf[s][i]   = 1'b0;
                last_c[s][i] = 0;
                last_o[s][i] = 1'b0;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NPE; i++) begin
                chk($sformatf("%s s%0d pe%0d c", tag, s, i), get_c(s, i), 0);
            end
        end
        chk({tag, " c_valid"}, int'(bus0.c_valid) | int'(bus1.c_valid), 0);
        chk({tag, " ovf"}, int'(bus0.ovf) | int'(bus1.ovf), 0);
    endtask

    // Monitor: pop on every strobe, otherwise require the outputs to hold.
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < NPE; i++) begin
                    if (get_cv(s, i)) begin
                        if (sb[s][i].size() == 0) begin
                            chk($sformatf("s%0d pe%0d spurious c_valid", s, i), 1, 0);
                        end else begin
                            mon_e = sb[s][i].pop_front();
                            chk($sformatf("s%0d pe%0d c", s, i), get_c(s, i), mon_e.c);
                            chk($sformatf("s%0d pe%0d ovf", s, i), int'(get_ovf(s, i)), int'(mon_e.ovf));
                            chk($sformatf("s%0d pe%0d edge", s, i), cyc, mon_e.cyc);
                            last_c[s][i] = mon_e.c;
                            last_o[s][i] = mon_e.ovf;
                        end
                    end else begin
                        chk($sformatf("s%0d pe%0d hold c", s, i), get_c(s, i), last_c[s][i]);
                        chk($sformatf("s%0d pe%0d hold ovf", s, i), int'(get_ovf(s, i)), int'(last_o[s][i]));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus0.in_valid = 1'b0;
        bus0.clr      = 1'b0;
        bus0.b        = '0;
        bus0.a        = {NPE{8'd5}};
        flush();

        // Reset held: everything zero.
        rst = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Basic accumulation: 10*5 = 50, then a0=20, b=15 -> 350 at PE0, PE1 gets 50 same edge.
        beat(1'b1, 10);
        set_a(0, 20);
        beat(1'b0, 15);
        idle(2);
        beat(1'b0, 1);
        idle(NPE + 1);
        chk("basic s0 pe0", get_c(0, 0), 370);
        chk("basic s0 pe1", get_c(0, 1), 130);
        chk("basic s1 pe3", get_c(1, 3), 130);

        // Clear mid-stream: PE0 restarts at 6 while PE1 still holds its old sum.
        set_a(0, 3);
        beat(1'b1, 2);
        chk("clr s0 pe0", get_c(0, 0), 6);
        chk("clr s0 pe0 ovf", int'(bus0.ovf[0]), 0);
        chk("clr s0 pe1 not yet", get_c(0, 1), 130);
        idle(NPE);
        chk("clr s0 pe1", get_c(0, 1), 10);
        chk("clr s1 pe3", get_c(1, 3), 10);

        // Overflow: 255*255 twice, then a saturated add, then a clearing beat.
        for (int i = 0; i < NPE; i++) set_a(i, 255);
        beat(1'b1, 255);
        beat(1'b0, 255);
        idle(NPE);
        chk("ovf sat c", get_c(0, 0), 65535);
        chk("ovf sat flag", int'(bus0.ovf[0]), 1);
        chk("ovf wrap c", get_c(1, 0), 64514);
        chk("ovf wrap flag", int'(bus1.ovf[3]), 1);
        beat(1'b0, 1);
        idle(NPE);
        chk("sat sticks", get_c(0, 2), 65535);
        chk("wrap adds", get_c(1, 2), 64769);
        beat(1'b1, 1);
        idle(NPE);
        chk("ovf cleared sat", int'(bus0.ovf), 0);
        chk("ovf cleared wrap c", get_c(1, 3), 255);

        // Asynchronous reset mid-stream, checked before the next edge.
        for (int i = 0; i < NPE; i++) set_a(i, 5);
        beat(1'b1, 3);
        beat(1'b0, 4);
        #1;
        rst = 1'b1;
        flush();
        #1;
        chk_zero("async reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        beat(1'b0, 7);
        idle(NPE);
        chk("post reset pe3", get_c(0, 3), 35);

        // Back-to-back sweep with random local operands.
        for (int i = 0; i < NPE; i++) set_a(i, int'($urandom_range(1, 60)));
        for (int k = 0; k < 8; k++) beat(k == 0, int'($urandom_range(0, 60)));
        idle(NPE + 2);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NPE; i++) begin
                chk($sformatf("s%0d pe%0d outstanding", s, i), sb[s][i].size(), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_nocpe_row
`default_nettype wire

// File: doc/nocpe_row.md
# nocpe_row

Parametrised 1xN chained processing-element row for the NoC PE array. A shared operand `b` enters PE 0 and ripples one PE per cycle down the chain; each PE multiplies it by its own local operand `a[i]` and accumulates into a per-PE accumulator. Compared with the fixed two-PE row it adds:
- a configurable PE count and configurable operand and accumulator widths;
- a valid/clear sideband that travels with `b`;
- per-PE output-valid strobes;
- selectable saturating or wrapping accumulation with sticky overflow flags.

## Interface
Parameters:
- `N`, 4: number of PEs in the chain (≥1)
- `DW`, 16: operand width, unsigned
- `AW`, 32: accumulator width, unsigned; must satisfy AW ≥ 2*DW
- `SAT`, 1: 1 = saturate at 2^AW−1; 0 = wrap modulo 2^AW

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `b`/`clr` are valid this cycle and enter PE 0
- `clr`  in  1  first beat of a new accumulation (qualified by `in_valid`)
- `b`  in  DW  shared operand into PE 0
- `a`  in  N*DW  local operands; `a[i*DW +: DW]` belongs to PE i and is sampled directly on the edge where PE i fires
- `c`  out  N*AW  accumulators; `c[i*AW +: AW]` belongs to PE i
- `c_valid`  out  N  `c_valid[i]` pulses high for one cycle after PE i updates
- `ovf`  out  N  sticky per-PE overflow flag

## Operation
- Chain registers per PE i: `b_q[i]`, `v_q[i]` and `clr_q[i]`. PE 0 sees `b`/`in_valid`/`clr` directly. PE i+1 sees PE i's registered copies, so it fires exactly one cycle after PE i for the same beat.
- Update when PE i fires (its valid is high):
  - `sum = (clr_i ? 0 : acc_i) + a[i]*b_i`, computed at AW+1 bits.
  - If `sum` ≥ 2^AW: SAT=1 loads 2^AW−1; SAT=0 loads `sum` mod 2^AW. In both modes `ovf[i]` is set.
  - A beat with `clr_i` high first clears `ovf[i]`, then sets it again if this beat overflows.
  - `c_valid[i]` is 1 on the cycle after the fire.
- When PE i does not fire: `acc_i`, `ovf[i]` and `c` hold; `c_valid[i]` is 0. `clr` with `in_valid` low is ignored and not propagated.
- A saturated accumulator stays at 2^AW−1 until the next `clr` (additions never decrease it).
- Reset: all accumulators, `c`, `c_valid`, `ovf`, `b_q`, `v_q` and `clr_q` go to 0 immediately and asynchronously. Any beats in flight are discarded. Accumulation resumes from 0 on the first valid beat after `rst` deasserts; no `clr` is needed.
- Back-to-back beats every cycle are supported; there is no stall or backpressure.

## Timing
- Beat presented with `in_valid`=1 before edge k:
  - `c[0]`/`c_valid[0]` update at edge k.
  - `c[i]`/`c_valid[i]` update at edge k+i, using `b` from edge k and `a[i]` present at edge k+i.
- Pipeline depth from the first beat to the last PE update: N−1 cycles after PE 0.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `clr` on beat k and a new valid beat on k+1 at PE 0 are independent. Each PE applies `clr` on the cycle the tagged beat reaches it, so PEs downstream still finish older beats first.

## Structure
- Package `nocpe_pkg`: default `DW`/`AW` localparams and a `sat_add` function (AW+1-bit sum, clamp or wrap, overflow bit).
- Sub-module `nocpe_cell` holds one PE: MAC plus accumulator, overflow and valid logic, plus the forwarding registers for `b`/`v`/`clr`.
- `nocpe_row` is a generate loop over N cells plus port slicing. The top level has no other logic.

## Test plan
- Reset: hold `rst`=1 → all `c`=0, `c_valid`=0, `ovf`=0. Assert `rst` mid-stream → outputs go to 0 asynchronously, before the next edge.
- N=2, all `a`=5:
  - Beat `b`=10 with `clr` → `c[0]`=50.
  - Next beat: `a0`=20, `b`=15 → `c[0]`=350 and `c[1]`=50 on the same edge.
  - One cycle later → `c[1]`=125.
- Bubble: drop `in_valid` for 2 cycles between beats → accumulators hold. `c_valid` shows the gap shifted by i cycles at each PE.
- Clear mid-stream: PE 0 at 350, then beat `b`=2 with `clr`, `a0`=3 → `c[0]`=6 and `ovf[0]`=0. Each downstream PE clears exactly one cycle later than the PE before it.
- Overflow, AW=16, DW=8, `a`=255, `b`=255, two beats:
  - SAT=1 → 65025, then 65535 with `ovf`=1.
  - SAT=0 → 65025, then 64514 with `ovf`=1.
  - A following `clr` beat clears `ovf`.
- N=4 sweep: 8 random back-to-back beats with `clr` on beat 0 → each `c[i]` equals the scoreboard sum of a[i]*b over the beats, checked at edge k+i.
